gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Synthesizable, self-timed exhaustive truth-table checker for any N-input primitive gate in the predefined gate library. It drives every input combination onto the gate under test and holds each one for a settle window. It then samples the gate output and compares it with a built-in reference model. It reports a pass/fail verdict, an error count and the first failing vector. It is the parametrised successor of the directed two-input gate benches and can be used in simulation or on-board.

Parameters:
N_IN, 2, number of gate inputs (1..8); sweep length is 2^N_IN vectors
OP, 0, reference operation: 0=AND, 1=OR, 2=XOR, 3=NAND, 4=NOR, 5=XNOR (reduction over all N_IN inputs)
SETTLE, 1, wait cycles after applying a vector before sampling (>=1)
ERR_W, 8, width of the error counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin sweep; accepted only in IDLE or DONE
stim  out  N_IN  vector driven to gate under test
dut_y  in  1  gate-under-test output
busy  out  1  high during sweep
done  out  1  high from sweep end until next start or rst
pass  out  1  done && err_count==0
err_count  out  ERR_W  mismatches, saturating
first_err_valid  out  1  at least one mismatch recorded this sweep
first_err_vec  out  N_IN  stim value of first mismatch

Behaviour:
- Reset (rst high at edge): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0. rst overrides start and aborts any sweep immediately; no partial result is kept.
- FSM states: IDLE, HOLD, CHECK, DONE.
- IDLE/DONE with start=1: next state HOLD. Set stim=0 and hold_cnt=SETTLE-1. Clear err_count, first_err_valid, first_err_vec and done. Set busy=1.
- HOLD: decrement hold_cnt each cycle. At 0, go to CHECK next cycle. stim is stable throughout.
- CHECK (one cycle): compare dut_y with expected = OP reduction of stim.
  - On mismatch: err_count += 1, holding at 2^ERR_W-1. If first_err_valid=0, latch first_err_vec=stim and set first_err_valid=1.
  - If stim is all ones: go to DONE, busy=0, done=1, stim=0.
  - Otherwise: stim+1, go to HOLD with hold_cnt=SETTLE-1.
- Each vector is presented for SETTLE+1 cycles and sampled in its last cycle.
- From the start edge to done rising: 2^N_IN*(SETTLE+1) cycles.
- start while busy is ignored; the sweep is not restarted.
- In DONE, results hold until start or rst. stim is 0 in IDLE and DONE.
- stim wrap: never increments past all ones; the sweep ends instead.
- N_IN=1: sweep has 2 vectors. Reduction of a single bit is the bit itself (NAND/NOR/XNOR give its inverse).
- err_count is sampled-registered; pass is combinational from done and err_count.

Decomposition:
- Shared package gate_pkg: OP encoding constants (OP_AND..OP_XNOR) and the state encoding for the FSM.
- One sub-module, gate_ref: combinational reference model, parameters N_IN and OP, input N_IN vector, output expected bit. Instantiated once inside gate_sweep_checker; reusable by other benches.
- The FSM, hold counter, stim counter and error capture stay in the top block.

Test Plan:
- N_IN=2, OP=AND, SETTLE=1, correct AND gate, pulse start: done rises exactly 8 cycles after start edge. pass=1, err_count=0, first_err_valid=0, stim sequence 00,01,10,11.
- N_IN=2, OP=AND, DUT is an OR gate: err_count=2, first_err_vec=2'b01, first_err_valid=1, pass=0.
- N_IN=3, OP=XNOR, SETTLE=2, dut_y stuck at 0: err_count=4 (vectors 000,011,101,110), first_err_vec=3'b000, done 24 cycles after start.
- N_IN=3, OP=AND, ERR_W=2, DUT inverted AND (NAND): 8 mismatches, err_count saturates at 3, first_err_vec=3'b000.
- Assert rst during HOLD of vector 2: next cycle all outputs at reset values. A following start runs a full clean sweep with pass=1 against a correct DUT.
- Pulse start mid-sweep: ignored, same timing as the uninterrupted sweep. Pulse start in DONE: done drops and err_count clears next cycle, and a new sweep runs.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate sweep checker: operation codes of the
// reference gate library and the sweep FSM state encoding.
package gate_pkg;

   localparam int OP_AND  = 0;
   localparam int OP_OR   = 1;
   localparam int OP_XOR  = 2;
   localparam int OP_NAND = 3;
   localparam int OP_NOR  = 4;
   localparam int OP_XNOR = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/gate_ref.sv
// Combinational reference model: reduction of all inputs with the selected
// library operation. A single input reduces to itself (or its inverse).
module gate_ref
   import gate_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int OP   = OP_AND
) (
   input  logic [N_IN-1:0] vec,
   output logic            expected
);

   // Select the reduction that defines the gate's truth table
   always_comb begin
      expected = 1'b0;
      case (OP)
         OP_AND:  expected = &vec;
         OP_OR:   expected = |vec;
         OP_XOR:  expected = ^vec;
         OP_NAND: expected = ~&vec;
         OP_NOR:  expected = ~|vec;
         OP_XNOR: expected = ~^vec;
         default: expected = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of an N_IN-input gate: each vector is held for
// SETTLE cycles plus one sampling cycle, compared with gate_ref, and the
// mismatch count and first failing vector are captured.
module gate_sweep_checker
   import gate_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int OP     = OP_AND,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [N_IN-1:0]  stim,
   input  logic             dut_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_err_valid,
   output logic [N_IN-1:0]  first_err_vec
);

   // Wide enough to hold SETTLE-1
   localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(SETTLE - 1);

   state_t           state_q, state_d;
   logic [N_IN-1:0]  stim_q, stim_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fev_q, fev_d;
   logic [N_IN-1:0]  fvec_q, fvec_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             expected;

   gate_ref #(
      .N_IN (N_IN),
      .OP   (OP)
   ) u_ref (
      .vec      (stim_q),
      .expected (expected)
   );

   // Next-state logic: sweep sequencing, hold countdown and error capture
   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      hold_d  = hold_q;
      err_d   = err_q;
      fev_d   = fev_q;
      fvec_d  = fvec_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_HOLD;
               stim_d  = '0;
               hold_d  = HOLD_INIT;
               err_d   = '0;
               fev_d   = 1'b0;
               fvec_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         ST_CHECK: begin
            if (dut_y != expected) begin
               // Saturate rather than wrap so a huge failure never reads as few
               if (err_q != '1) begin
                  err_d = err_q + ERR_W'(1);
               end
               if (!fev_q) begin
                  fev_d  = 1'b1;
                  fvec_d = stim_q;
               end
            end
            if (stim_q == '1) begin
               state_d = ST_DONE;
               stim_d  = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d = ST_HOLD;
               stim_d  = stim_q + N_IN'(1);
               hold_d  = HOLD_INIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any sweep and discards partial results
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         stim_q  <= '0;
         hold_q  <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fvec_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fvec_q  <= fvec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign stim            = stim_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err_count       = err_q;
   assign first_err_valid = fev_q;
   assign first_err_vec   = fvec_q;
   assign pass            = done_q && (err_q == '0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: three checker instances (2-input AND with a switchable
// AND/OR gate, 3-input XNOR with a stuck-at-0 gate, 3-input AND with a NAND
// gate and a 2-bit error counter).
module tb_gate_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // Instance A: N_IN=2, AND, SETTLE=1
   logic       start_a = 1'b0;
   logic       a_or    = 1'b0;
   logic [1:0] stim_a;
   logic       y_a, busy_a, done_a, pass_a, fev_a;
   logic [7:0] err_a;
   logic [1:0] fvec_a;
   assign y_a = a_or ? |stim_a : &stim_a;

   gate_sweep_checker #(.N_IN(2), .OP(0), .SETTLE(1), .ERR_W(8)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_y(y_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_err_valid(fev_a), .first_err_vec(fvec_a));

   // Instance B: N_IN=3, XNOR, SETTLE=2, gate stuck at 0
   logic       start_b = 1'b0;
   logic       y_b     = 1'b0;
   logic [2:0] stim_b;
   logic       busy_b, done_b, pass_b, fev_b;
   logic [7:0] err_b;
   logic [2:0] fvec_b;

   gate_sweep_checker #(.N_IN(3), .OP(5), .SETTLE(2), .ERR_W(8)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_y(y_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_err_valid(fev_b), .first_err_vec(fvec_b));

   // Instance C: N_IN=3, AND, SETTLE=1, ERR_W=2, gate is NAND
   logic       start_c = 1'b0;
   logic [2:0] stim_c;
   logic       y_c, busy_c, done_c, pass_c, fev_c;
   logic [1:0] err_c;
   logic [2:0] fvec_c;
   assign y_c = ~&stim_c;

   gate_sweep_checker #(.N_IN(3), .OP(0), .SETTLE(1), .ERR_W(2)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .stim(stim_c), .dut_y(y_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
      .first_err_valid(fev_c), .first_err_vec(fvec_c));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a_reset(input string tag);
      check({tag, " stim"}, 32'(stim_a), 0);
      check({tag, " busy"}, 32'(busy_a), 0);
      check({tag, " done"}, 32'(done_a), 0);
      check({tag, " pass"}, 32'(pass_a), 0);
      check({tag, " err"},  32'(err_a), 0);
      check({tag, " fev"},  32'(fev_a), 0);
      check({tag, " fvec"}, 32'(fvec_a), 0);
   endtask

   int n;

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check_a_reset("reset");
      check("reset b done", 32'(done_b), 0);
      check("reset c busy", 32'(busy_c), 0);

      // Clean AND sweep: cycle-exact stim sequence and done timing
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("a1 k0 busy", 32'(busy_a), 1);
      check("a1 k0 stim", 32'(stim_a), 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         $display("a1 cycle %0d stim=%0b busy=%0b done=%0b", k, stim_a, busy_a, done_a);
         check($sformatf("a1 k%0d stim", k), 32'(stim_a), (k < 8) ? 32'(k / 2) : 0);
         check($sformatf("a1 k%0d done", k), 32'(done_a), (k == 8) ? 1 : 0);
         check($sformatf("a1 k%0d busy", k), 32'(busy_a), (k < 8) ? 1 : 0);
      end
      check("a1 pass", 32'(pass_a), 1);
      check("a1 err", 32'(err_a), 0);
      check("a1 fev", 32'(fev_a), 0);

      // OR gate against AND model, started from DONE, start pulsed mid-sweep
      a_or    = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("a2 restart done", 32'(done_a), 0);
      check("a2 restart busy", 32'(busy_a), 1);
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) start_a = 1'b1;
         tick();
         start_a = 1'b0;
         check($sformatf("a2 k%0d done", k), 32'(done_a), (k == 8) ? 1 : 0);
      end
      $display("a2 sweep err=%0d fvec=%0b pass=%0b", err_a, fvec_a, pass_a);
      check("a2 err", 32'(err_a), 2);
      check("a2 fev", 32'(fev_a), 1);
      check("a2 fvec", 32'(fvec_a), 1);
      check("a2 pass", 32'(pass_a), 0);
      tick();
      check("a2 hold done", 32'(done_a), 1);
      check("a2 hold err", 32'(err_a), 2);

      // Restart clears results; then reset during HOLD of vector 2
      a_or    = 1'b0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("a3 clr err", 32'(err_a), 0);
      check("a3 clr fev", 32'(fev_a), 0);
      check("a3 clr done", 32'(done_a), 0);
      for (int k = 1; k <= 4; k++) tick();
      check("a3 vec2 stim", 32'(stim_a), 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_a_reset("a3 abort");

      // Clean sweep after abort
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      n = 0;
      while (!done_a && n < 100) begin
         tick();
         n++;
      end
      $display("a4 sweep cycles=%0d pass=%0b err=%0d", n, pass_a, err_a);
      check("a4 cycles", 32'(n), 8);
      check("a4 pass", 32'(pass_a), 1);
      check("a4 err", 32'(err_a), 0);

      // XNOR, SETTLE=2, stuck-at-0
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      n = 0;
      while (!done_b && n < 200) begin
         tick();
         n++;
      end
      $display("b sweep cycles=%0d err=%0d fvec=%0b", n, err_b, fvec_b);
      check("b cycles", 32'(n), 24);
      check("b err", 32'(err_b), 4);
      check("b fev", 32'(fev_b), 1);
      check("b fvec", 32'(fvec_b), 0);
      check("b pass", 32'(pass_b), 0);
      check("b stim", 32'(stim_b), 0);

      // AND model vs NAND gate, 2-bit counter saturates
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      n = 0;
      while (!done_c && n < 200) begin
         tick();
         n++;
      end
      $display("c sweep cycles=%0d err=%0d fvec=%0b", n, err_c, fvec_c);
      check("c cycles", 32'(n), 16);
      check("c err", 32'(err_c), 3);
      check("c fev", 32'(fev_c), 1);
      check("c fvec", 32'(fvec_c), 0);
      check("c pass", 32'(pass_c), 0);
      check("c busy", 32'(busy_c), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
